// File: rtl/fpu_pkg.sv
// Shared FPU constants and float field layout, common to fadd and ftoi_pipe.
package fpu_pkg;

  localparam int EXP_W       = 8;
  localparam int FRAC_W      = 23;
  localparam int EXP_BIAS    = 127;
  localparam int EXP_INT_MAX = 158;
  localparam int EXP_NOSHIFT = 150;

  localparam logic [31:0] INT_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_NEG_SAT = 32'h8000_0000;

  localparam int RND_RNE = 0;
  localparam int RND_RTZ = 1;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } float_t;

  // Stage-1 result: significand plus precomputed shift and classification
  typedef struct packed {
    logic              sign;
    logic [FRAC_W:0]   sig;
    logic              shl;
    logic [2:0]        lsh;
    logic [7:0]        rsh;
    logic              ovf;
    logic              neg_min;
  } unpack_t;

endpackage

// File: rtl/ftoi_round.sv
// Combinational shift-and-round: denormalises the significand into a 31-bit magnitude.
module ftoi_round
  import fpu_pkg::*;
#(
  parameter int ROUND_MODE = RND_RNE
) (
  input  logic [FRAC_W:0] sig,
  input  logic            shl,
  input  logic [2:0]      lsh,
  input  logic [7:0]      rsh,
  output logic [30:0]     mag
);

  logic [47:0] ext_s;
  logic [30:0] trunc_s;
  logic        guard_s;
  logic        sticky_s;
  logic        inc_s;

  // Shift into integer position, keep guard and sticky, then round
  always_comb begin
    ext_s    = 48'd0;
    trunc_s  = 31'd0;
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    inc_s    = 1'b0;
    if (shl) begin
      trunc_s = {7'd0, sig} << lsh;
    end else if (rsh > 8'd24) begin
      // Below 0.5: every bit is lost, only stickiness survives
      sticky_s = |sig;
    end else begin
      ext_s    = {sig, 24'd0} >> rsh;
      trunc_s  = {7'd0, ext_s[47:24]};
      guard_s  = ext_s[23];
      sticky_s = |ext_s[22:0];
    end
    if (ROUND_MODE == RND_RNE) begin
      inc_s = guard_s && (sticky_s || trunc_s[0]);
    end else begin
      inc_s = 1'b0;
    end
    mag = trunc_s + {30'd0, inc_s};
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Three-stage float-to-int32 converter with valid/ready stream and whole-pipe stall.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int ROUND_MODE = RND_RNE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf
);

  float_t      flt_s;
  unpack_t     unpack_s;
  unpack_t     u1_r;
  logic        v1_r;
  logic        v2_r;
  logic        s2_r;
  logic        ovf2_r;
  logic        min2_r;
  logic [30:0] mag2_r;
  logic [30:0] mag_s;
  logic [31:0] res_s;
  logic        stall_s;

  assign stall_s  = out_valid && !out_ready;
  assign in_ready = !stall_s;
  assign flt_s    = in_data;

  // Stage 1: unpack, classify and compute shift direction and amount
  always_comb begin
    unpack_s         = '0;
    unpack_s.sign    = flt_s.sign;
    unpack_s.sig     = (flt_s.exp == 8'd0) ? 24'd0 : {1'b1, flt_s.frac};
    unpack_s.neg_min = flt_s.sign && (flt_s.exp == 8'(EXP_INT_MAX)) && (flt_s.frac == 23'd0);
    unpack_s.ovf     = (flt_s.exp == 8'hFF) ||
                       ((flt_s.exp >= 8'(EXP_INT_MAX)) && !unpack_s.neg_min);
    if (flt_s.exp < 8'(EXP_NOSHIFT)) begin
      unpack_s.shl = 1'b0;
      unpack_s.rsh = 8'(EXP_NOSHIFT) - flt_s.exp;
      unpack_s.lsh = 3'd0;
    end else begin
      // Only exponents 150..157 reach the datapath; larger ones saturate
      unpack_s.shl = 1'b1;
      unpack_s.rsh = 8'd0;
      unpack_s.lsh = 3'(flt_s.exp - 8'(EXP_NOSHIFT));
    end
  end

  ftoi_round #(
    .ROUND_MODE (ROUND_MODE)
  ) u_round (
    .sig (u1_r.sig),
    .shl (u1_r.shl),
    .lsh (u1_r.lsh),
    .rsh (u1_r.rsh),
    .mag (mag_s)
  );

  // Stage 3: apply sign or saturate
  always_comb begin
    res_s = 32'd0;
    if (ovf2_r) begin
      res_s = s2_r ? INT_NEG_SAT : INT_POS_SAT;
    end else if (min2_r) begin
      res_s = INT_NEG_SAT;
    end else if (s2_r) begin
      res_s = 32'd0 - {1'b0, mag2_r};
    end else begin
      res_s = {1'b0, mag2_r};
    end
  end

  // Pipeline registers: all stages advance together unless the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r      <= 1'b0;
      u1_r      <= '0;
      v2_r      <= 1'b0;
      s2_r      <= 1'b0;
      ovf2_r    <= 1'b0;
      min2_r    <= 1'b0;
      mag2_r    <= 31'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_ovf   <= 1'b0;
    end else if (!stall_s) begin
      v1_r      <= in_valid;
      u1_r      <= unpack_s;
      v2_r      <= v1_r;
      s2_r      <= u1_r.sign;
      ovf2_r    <= u1_r.ovf;
      min2_r    <= u1_r.neg_min;
      mag2_r    <= mag_s;
      out_valid <= v2_r;
      out_data  <= res_s;
      out_ovf   <= ovf2_r;
    end
  end

endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
- Pipelined converter from IEEE-754 single-precision to 32-bit two's-complement signed integer.
- It is the decode-direction counterpart to the team's combinational fadd datapath. fadd normalises integer-like sums into packed floats; this block unpacks a float and denormalises it back into an integer.
- Sits beside fadd in the FPU, fed by the issue logic through a valid/ready stream, and drives the integer writeback.
- Three-stage pipeline, one conversion accepted per cycle.

Parameters:
- ROUND_MODE, default 0: 0 = round-to-nearest-even; 1 = truncate toward zero (C cast semantics).

Ports:
- clk, input, 1: single clock. Every register updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_data holds a float to convert.
- in_ready, output, 1: block accepts in_data this cycle.
- in_data, input, 32: packed float, fields {sign[31], exp[30:23], frac[22:0]}.
- out_valid, output, 1: out_data and out_ovf are valid.
- out_ready, input, 1: consumer takes the result this cycle.
- out_data, output, 32: signed integer result.
- out_ovf, output, 1: out-of-range input or Inf/NaN; out_data is saturated.

Behaviour:
- Reset:
  - rst is synchronous and active-high.
  - While rst is high at a clk edge, all stage valid bits clear, out_valid=0, out_data=0, out_ovf=0.
  - In-flight conversions are discarded, not flushed.
  - in_ready=1 in the first cycle after reset releases.
- Handshake:
  - Transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output).
  - stall = out_valid && !out_ready. When stall=1 every stage holds, including stage valids, data and out_* registers.
  - in_ready = !stall. This is a combinational path from out_ready, which is accepted.
  - Bubbles are not collapsed.
  - While stalled, out_data and out_ovf must stay stable.
- Latency and throughput:
  - Exactly 3 clk edges from input transfer to out_valid when no stall occurs.
  - Throughput is 1 per cycle.
  - Order is preserved; no loss, no duplication.
- Stage 1, unpack:
  - Capture sign s, exponent e, significand m = {1, frac}, or 0 if e==0 (zero/denormal gives result 0, ovf=0).
  - Classify: e==255 is special; e>=158 is range overflow.
  - Compute shift: right shift = 150-e when e<150; left shift = e-150 when 150<=e<=157.
- Stage 2, shift and round:
  - Shift m into a 31-bit magnitude with guard bit g and sticky bit st (OR of all lost bits).
  - If e<126, magnitude=0, g=0, st = (m!=0).
  - RNE: increment magnitude when g && (st || lsb).
  - Truncate: never increment.
  - Magnitude cannot exceed 2^31-1 after rounding for e<=157.
- Stage 3, sign and saturate:
  - out_data = s ? -mag : mag.
  - If e==255, or e>=158 except the exact value -2^31 (s=1, e=158, frac=0): out_data = s ? 32'h80000000 : 32'h7FFFFFFF, out_ovf=1.
  - The exact value -2^31 gives 32'h80000000 with out_ovf=0.
  - NaN saturates by its sign bit.
  - Negative zero and negative values that round to 0 give 32'h00000000.
- Simultaneous events:
  - Input acceptance and output retirement in the same cycle are both honoured.
  - rst overrides in_valid and out_ready in the same cycle.

Decomposition:
- Package fpu_pkg holds:
  - EXP_BIAS=127, EXP_INT_MAX=158, EXP_NOSHIFT=150.
  - INT_POS_SAT=32'h7FFFFFFF, INT_NEG_SAT=32'h80000000.
  - Round-mode constants RND_RNE=0, RND_RTZ=1.
  - Float field widths (EXP_W=8, FRAC_W=23).
  - Shared with fadd.
- One sub-module: ftoi_round. It is the combinational stage-2 logic: shift, guard/sticky and increment. It is parameterised by ROUND_MODE and instanced between the stage-1 and stage-2 registers.

Test Plan:
- Rounding with RNE: 0x3FC00000 (1.5)→2; 0x40200000 (2.5)→2; 0xC0600000 (-3.5)→0xFFFFFFFC; 0x3F000000 (0.5)→0; 0x3F000001→1; all ovf=0. With ROUND_MODE=1: 1.5→1, -3.5→0xFFFFFFFD.
- Range edges:
  - 0x4EFFFFFF→0x7FFFFF80, ovf=0.
  - 0x4F000000 (2^31)→0x7FFFFFFF, ovf=1.
  - 0xCF000000→0x80000000, ovf=0.
  - 0xCF000001→0x80000000, ovf=1.
- Specials: 0x7F800000→0x7FFFFFFF, ovf=1; 0xFF800000→0x80000000, ovf=1; 0xFFC00000→0x80000000, ovf=1; 0x80000000→0; 0x00000001→0, ovf=0.
- Latency: single input 0x42F60000 (123.0) at cycle 0 with out_ready=1 → out_valid first high after the 3rd edge, out_data=123 for one cycle.
- Backpressure:
  - Setup: stream 1.0, 2.0, 3.0, 4.0, 5.0 back-to-back; hold out_ready low for cycles 4–6.
  - Required: in_ready low in exactly those cycles; outputs 1..5 in order, each exactly once; out_data constant during the stall.
- Reset mid-stream: assert rst for 1 cycle while 3 conversions are in flight → next cycle out_valid=0, out_data=0, out_ovf=0, in_ready=1; none of the discarded results ever appear.
